spi_sram_ctrl: RTL and testbench

- Memory-side stage directly downstream of the x3q16 core.
- Serves the core's single-word request handshake (request / request_type / request_address / data_out) and returns memory_in, memory_ready, write_complete and memory_critical.
- Backs the core's 16-bit word-addressed space with an external SPI SRAM (mode 0, READ 0x03 / WRITE 0x02, 24-bit byte address).
- Includes a one-deep pending slot so a request issued during the inter-transaction gap is not lost.

---
 rtl/spi_sram_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spi_sram_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_ctrl.sv
// Single-word SPI SRAM bridge for the x3q16 core: one 48-bit mode-0 frame per word,
// with a one-deep pending slot so requests arriving while busy are not lost.
module spi_sram_ctrl #(
    parameter int          CLK_DIV   = 2,
    parameter int          CS_GAP    = 4,
    parameter logic [15:0] CRIT_ADDR = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request,
    input  logic        request_type,
    input  logic [15:0] request_address,
    input  logic [15:0] data_out,
    output logic [15:0] memory_in,
    output logic        memory_ready,
    output logic        write_complete,
    output logic        memory_critical,
    output logic        busy,
    output logic        req_dropped,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_bit;
    logic [GAP_W-1:0] r_gap;
    logic [47:0]      r_tx;
    logic [15:0]      r_rx;
    logic             r_type;
    logic [15:0]      r_addr;
    logic             r_pend_valid;
    logic             r_pend_type;
    logic [15:0]      r_pend_addr;
    logic [15:0]      r_pend_data;
    logic             r_sclk;
    logic             r_cs_n;
    logic             r_mosi;
    logic [15:0]      r_memory_in;
    logic             r_memory_ready;
    logic             r_write_complete;
    logic             r_memory_critical;
    logic             r_busy;

    logic        w_gap_end;
    logic        w_take_pend;
    logic        w_take_req;
    logic        w_start;
    logic        w_s_type;
    logic [15:0] w_s_addr;
    logic [15:0] w_s_data;
    logic [47:0] w_frame;
    logic        w_store;
    logic        w_drop;

    // A request seen on the last GAP cycle with an empty slot starts directly,
    // exactly as it would from IDLE; a full slot always wins the start instead.
    always_comb begin
        w_gap_end   = (r_state == S_GAP) && (r_gap == GAP_LAST);
        w_take_pend = w_gap_end && r_pend_valid;
        w_take_req  = request && ((r_state == S_IDLE) || (w_gap_end && !r_pend_valid));
        w_start     = w_take_pend || w_take_req;
        w_s_type    = w_take_pend ? r_pend_type : request_type;
        w_s_addr    = w_take_pend ? r_pend_addr : request_address;
        w_s_data    = w_take_pend ? r_pend_data : data_out;
        w_frame     = {(w_s_type ? 8'h02 : 8'h03), 7'b0, w_s_addr, 1'b0,
                       (w_s_type ? w_s_data : 16'h0000)};
        w_store     = request && !w_take_req && (!r_pend_valid || w_take_pend);
        w_drop      = request && !w_take_req && r_pend_valid && !w_take_pend;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_div             <= '0;
            r_bit             <= '0;
            r_gap             <= '0;
            r_tx              <= '0;
            r_rx              <= '0;
            r_type            <= 1'b0;
            r_addr            <= '0;
            r_pend_valid      <= 1'b0;
            r_pend_type       <= 1'b0;
            r_pend_addr       <= '0;
            r_pend_data       <= '0;
            r_sclk            <= 1'b0;
            r_cs_n            <= 1'b1;
            r_mosi            <= 1'b0;
            r_memory_in       <= '0;
            r_memory_ready    <= 1'b0;
            r_write_complete  <= 1'b0;
            r_memory_critical <= 1'b0;
            r_busy            <= 1'b0;
        end else begin
            r_memory_ready    <= 1'b0;
            r_write_complete  <= 1'b0;
            r_memory_critical <= 1'b0;

            if (w_take_pend) r_pend_valid <= 1'b0;
            if (w_store) begin
                r_pend_valid <= 1'b1;
                r_pend_type  <= request_type;
                r_pend_addr  <= request_address;
                r_pend_data  <= data_out;
            end

            case (r_state)
                S_SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[14:0], miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == 6'd47) begin
                                r_state <= S_DONE;
                                r_mosi  <= 1'b0;
                            end else begin
                                r_bit  <= r_bit + 6'd1;
                                r_mosi <= r_tx[47];
                                r_tx   <= {r_tx[46:0], 1'b0};
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_cs_n <= 1'b1;
                    if (r_type) begin
                        r_write_complete  <= 1'b1;
                        r_memory_critical <= (r_addr >= CRIT_ADDR);
                    end else begin
                        r_memory_in    <= r_rx;
                        r_memory_ready <= 1'b1;
                    end
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (!w_gap_end) begin
                        r_gap <= r_gap + 1'b1;
                    end else if (!w_start) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase

            // Start of a frame: first bit is presented together with cs_n falling.
            if (w_start) begin
                r_state <= S_SHIFT;
                r_busy  <= 1'b1;
                r_cs_n  <= 1'b0;
                r_sclk  <= 1'b0;
                r_mosi  <= w_frame[47];
                r_tx    <= {w_frame[46:0], 1'b0};
                r_div   <= '0;
                r_bit   <= '0;
                r_type  <= w_s_type;
                r_addr  <= w_s_addr;
            end
        end
    end

    assign memory_in       = r_memory_in;
    assign memory_ready    = r_memory_ready;
    assign write_complete  = r_write_complete;
    assign memory_critical = r_memory_critical;
    assign busy            = r_busy;
    assign req_dropped     = w_drop;
    assign sclk            = r_sclk;
    assign cs_n            = r_cs_n;
    assign mosi            = r_mosi;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: a mode-0 SPI SRAM slave model captures frames
// and returns read data; each scenario task compares against hand-computed values.
module tb_spi_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        request;
    logic        request_type;
    logic [15:0] request_address;
    logic [15:0] data_out;
    logic [15:0] memory_in;
    logic        memory_ready;
    logic        write_complete;
    logic        memory_critical;
    logic        busy;
    logic        req_dropped;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso = 1'b0;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    spi_sram_ctrl #(.CLK_DIV(2), .CS_GAP(4), .CRIT_ADDR(16'hFF00)) dut (
        .clk(clk), .reset(reset), .request(request), .request_type(request_type),
        .request_address(request_address), .data_out(data_out),
        .memory_in(memory_in), .memory_ready(memory_ready),
        .write_complete(write_complete), .memory_critical(memory_critical),
        .busy(busy), .req_dropped(req_dropped), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .dbg_state(dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_cyc  = 0;
    int mr_cnt = 0, wc_cnt = 0, crit_cnt = 0, both_cnt = 0, drop_cnt = 0, starts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memory_ready === 1'b1) mr_cnt++;
        if (write_complete === 1'b1) wc_cnt++;
        if (memory_critical === 1'b1) crit_cnt++;
        if (memory_ready === 1'b1 && write_complete === 1'b1) both_cnt++;
    end

    always @(posedge clk) if (req_dropped === 1'b1) drop_cnt++;

    // ---------------- SPI SRAM slave model ----------------
    logic [47:0] slv_sr = '0;
    int          slv_cnt = 0;
    logic [15:0] slv_rd = '0;
    logic [47:0] frames_q[$];
    logic [47:0] exp_q[$];

    function automatic logic [15:0] rd_model(input logic [23:0] a);
        if (a == 24'h000024) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n === 1'b1) begin
            if (slv_cnt == 48) frames_q.push_back(slv_sr);
            slv_cnt = 0;
        end else begin
            slv_sr = {slv_sr[46:0], mosi};
            slv_cnt++;
        end
    end

    always @(negedge sclk) begin
        if (cs_n === 1'b0 && slv_cnt >= 32 && slv_cnt < 48) begin
            if (slv_cnt == 32) slv_rd = rd_model(slv_sr[23:0]);
            miso = slv_rd[47 - slv_cnt];
        end else begin
            miso = 1'b0;
        end
    end

    always @(negedge cs_n) starts++;

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic t, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        request = 1'b1; request_type = t; request_address = a; data_out = d;
        req_cyc = cyc;
        @(negedge clk);
        request = 1'b0;
    endtask

    // which: 0 = memory_ready, 1 = write_complete, 2 = busy low
    task automatic wait_sig(input int which, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && memory_ready === 1'b1) ||
                (which == 1 && write_complete === 1'b1) ||
                (which == 2 && busy === 1'b0)) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    bit found;
    int lat, rd_cyc, base0, base1, base2;

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0; request = 1'b1; request_type = 1'b1;
        request_address = 16'h1234; data_out = 16'h5678;
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (memory_in !== 16'h0) begin failures++; $display("FAIL reset_memory_in: got %h expected 0000", memory_in); end
        checks++; if ({memory_ready, write_complete, memory_critical, req_dropped} !== 4'b0)
            begin failures++; $display("FAIL reset_pulses: got %b expected 0000",
                {memory_ready, write_complete, memory_critical, req_dropped}); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        request = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read;
        frames_q.delete();
        drive_req(1'b0, 16'h0012, 16'h0000);
        wait_sig(0, 400, found);
        lat = cyc - req_cyc; rd_cyc = cyc;
        checks++; if (!found) begin failures++; $display("FAIL read_timeout: got none expected memory_ready"); end
        checks++; if (lat != 194) begin failures++; $display("FAIL read_latency: got %0d expected 194", lat); end
        checks++; if (memory_in !== 16'hBEEF) begin failures++; $display("FAIL read_data: got %h expected beef", memory_in); end
        checks++; if (write_complete !== 1'b0) begin failures++; $display("FAIL read_wc: got %b expected 0", write_complete); end
        wait_sig(2, 20, found);
        checks++; if (!found || cyc - rd_cyc != 4) begin failures++; $display("FAIL read_busy_fall: got %0d expected 4", cyc - rd_cyc); end
        repeat (3) @(negedge clk);
        checks++; if (frames_q.size() != 1) begin failures++; $display("FAIL read_frames: got %0d expected 1", frames_q.size()); end
        else begin
            checks++; if (frames_q[0][47:40] !== 8'h03) begin failures++; $display("FAIL read_cmd: got %h expected 03", frames_q[0][47:40]); end
            checks++; if (frames_q[0][39:16] !== 24'h000024) begin failures++; $display("FAIL read_addr: got %h expected 000024", frames_q[0][39:16]); end
            checks++; if (frames_q[0][15:0] !== 16'h0000) begin failures++; $display("FAIL read_mosi_tail: got %h expected 0000", frames_q[0][15:0]); end
        end
        checks++; if (memory_in !== 16'hBEEF) begin failures++; $display("FAIL read_hold: got %h expected beef", memory_in); end
    endtask

    task automatic test_write;
        frames_q.delete();
        base0 = wc_cnt;
        drive_req(1'b1, 16'h0100, 16'hA55A);
        wait_sig(1, 400, found);
        checks++; if (!found || cyc - req_cyc != 194) begin failures++; $display("FAIL write_latency: got %0d expected 194", cyc - req_cyc); end
        checks++; if (memory_critical !== 1'b0) begin failures++; $display("FAIL write_crit: got %b expected 0", memory_critical); end
        checks++; if (memory_ready !== 1'b0) begin failures++; $display("FAIL write_mr: got %b expected 0", memory_ready); end
        wait_sig(2, 20, found);
        repeat (5) @(negedge clk);
        checks++; if (wc_cnt - base0 != 1) begin failures++; $display("FAIL write_wc_count: got %0d expected 1", wc_cnt - base0); end
        checks++; if (frames_q.size() != 1 || frames_q[0] !== {8'h02, 24'h000200, 16'hA55A})
            begin failures++; $display("FAIL write_frame: got %h expected 02000200a55a",
                (frames_q.size() > 0) ? frames_q[0] : 48'h0); end
    endtask

    task automatic test_critical;
        frames_q.delete();
        base0 = crit_cnt;
        drive_req(1'b1, 16'hFF00, 16'h1111);
        wait_sig(1, 400, found);
        checks++; if (!found || memory_critical !== 1'b1) begin failures++; $display("FAIL crit_ff00: got %b expected 1", memory_critical); end
        wait_sig(2, 20, found);
        drive_req(1'b1, 16'hFEFF, 16'h2222);
        wait_sig(1, 400, found);
        checks++; if (!found || memory_critical !== 1'b0) begin failures++; $display("FAIL crit_feff: got %b expected 0", memory_critical); end
        wait_sig(2, 20, found);
        repeat (2) @(negedge clk);
        checks++; if (crit_cnt - base0 != 1) begin failures++; $display("FAIL crit_count: got %0d expected 1", crit_cnt - base0); end
        checks++; if (frames_q.size() != 2 || frames_q[1][39:16] !== 24'h01FDFE)
            begin failures++; $display("FAIL crit_addr: got %h expected 01fdfe",
                (frames_q.size() > 1) ? frames_q[1][39:16] : 24'h0); end
    endtask

    task automatic test_pend;
        int hi;
        frames_q.delete();
        base0 = drop_cnt;
        drive_req(1'b0, 16'h0012, 16'h0000);
        repeat (8) @(negedge clk);
        drive_req(1'b1, 16'h0300, 16'h1234);
        wait_sig(0, 400, found);
        rd_cyc = cyc;
        checks++; if (!found || memory_in !== 16'hBEEF) begin failures++; $display("FAIL pend_read_data: got %h expected beef", memory_in); end
        checks++; if (dbg_state !== 2'd3) begin failures++; $display("FAIL pend_gap_state: got %0d expected 3", dbg_state); end
        hi = 0;
        while (cs_n === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        checks++; if (hi != 4) begin failures++; $display("FAIL pend_cs_gap: got %0d expected 4", hi); end
        checks++; if (cyc - rd_cyc != 4) begin failures++; $display("FAIL pend_start: got %0d expected 4", cyc - rd_cyc); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pend_busy: got %b expected 1", busy); end
        wait_sig(1, 400, found);
        checks++; if (!found) begin failures++; $display("FAIL pend_write_timeout: got none expected write_complete"); end
        wait_sig(2, 20, found);
        repeat (2) @(negedge clk);
        checks++; if (frames_q.size() != 2 || frames_q[1] !== {8'h02, 24'h000600, 16'h1234})
            begin failures++; $display("FAIL pend_frame: got %h expected 020006001234",
                (frames_q.size() > 1) ? frames_q[1] : 48'h0); end
        checks++; if (drop_cnt != base0) begin failures++; $display("FAIL pend_drop: got %0d expected 0", drop_cnt - base0); end
    endtask

    task automatic test_back_to_back;
        logic [47:0] got;
        frames_q.delete();
        exp_q.delete();
        exp_q.push_back({8'h03, 24'h000080, 16'h0000});
        exp_q.push_back({8'h02, 24'h000082, 16'hCAFE});
        base0 = drop_cnt; base1 = mr_cnt; base2 = starts;
        @(negedge clk);
        request = 1'b1; request_type = 1'b0; request_address = 16'h0040; data_out = 16'h0000;
        @(negedge clk);
        request_type = 1'b1; request_address = 16'h0041; data_out = 16'hCAFE;
        #1;
        checks++; if (req_dropped !== 1'b0) begin failures++; $display("FAIL b2b_second_drop: got %b expected 0", req_dropped); end
        @(negedge clk);
        request_type = 1'b0; request_address = 16'h0042; data_out = 16'h0000;
        #1;
        checks++; if (req_dropped !== 1'b1) begin failures++; $display("FAIL b2b_third_drop: got %b expected 1", req_dropped); end
        @(negedge clk);
        request = 1'b0;
        wait_sig(0, 400, found);
        checks++; if (!found || memory_in !== 16'h5ADA) begin failures++; $display("FAIL b2b_read_data: got %h expected 5ada", memory_in); end
        wait_sig(1, 400, found);
        checks++; if (!found) begin failures++; $display("FAIL b2b_write_timeout: got none expected write_complete"); end
        wait_sig(2, 20, found);
        repeat (20) @(negedge clk);
        checks++; if (drop_cnt - base0 != 1) begin failures++; $display("FAIL b2b_drop_count: got %0d expected 1", drop_cnt - base0); end
        checks++; if (mr_cnt - base1 != 1) begin failures++; $display("FAIL b2b_read_count: got %0d expected 1", mr_cnt - base1); end
        checks++; if (starts - base2 != 2) begin failures++; $display("FAIL b2b_spi_starts: got %0d expected 2", starts - base2); end
        checks++; if (frames_q.size() != 2) begin failures++; $display("FAIL b2b_frames: got %0d expected 2", frames_q.size()); end
        while (frames_q.size() > 0 && exp_q.size() > 0) begin
            got = frames_q.pop_front();
            checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL b2b_frame_order: got %h expected %h", got, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_abort;
        frames_q.delete();
        base1 = mr_cnt;
        drive_req(1'b0, 16'h0033, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (slv_cnt >= 20) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL abort_reach_bit20: got %0d expected 20", slv_cnt); end
        #3 reset = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1 || sclk !== 1'b0) begin failures++; $display("FAIL abort_async: got cs_n=%b sclk=%b expected cs_n=1 sclk=0", cs_n, sclk); end
        checks++; if (busy !== 1'b0 || memory_in !== 16'h0) begin failures++; $display("FAIL abort_regs: got busy=%b memory_in=%h expected 0/0000", busy, memory_in); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (250) @(negedge clk);
        checks++; if (mr_cnt != base1) begin failures++; $display("FAIL abort_no_ready: got %0d expected 0", mr_cnt - base1); end
        checks++; if (frames_q.size() != 0) begin failures++; $display("FAIL abort_no_frame: got %0d expected 0", frames_q.size()); end
        drive_req(1'b0, 16'h0012, 16'h0000);
        wait_sig(0, 400, found);
        checks++; if (!found || cyc - req_cyc != 194) begin failures++; $display("FAIL abort_fresh_latency: got %0d expected 194", cyc - req_cyc); end
        checks++; if (memory_in !== 16'hBEEF) begin failures++; $display("FAIL abort_fresh_data: got %h expected beef", memory_in); end
        wait_sig(2, 20, found);
    endtask

    initial begin
        reset = 1'b0; request = 1'b0; request_type = 1'b0;
        request_address = '0; data_out = '0;
        test_reset();
        test_read();
        test_write();
        test_critical();
        test_pend();
        test_back_to_back();
        test_reset_abort();
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL ready_and_wc_overlap: got %0d expected 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
